// File: rtl/tile_collide_query_pkg.sv
// Shared types and constants for the tile collision query block.
// Also holds the clamp helper that maps a signed tile index into room bounds.
package tile_collide_query_pkg;

  localparam int TILE_SHIFT = 3;
  localparam int MAP_W_DEF = 16;
  localparam int MAP_H_DEF = 16;
  localparam logic [7:0] SOLID_MASK_DEF = 8'h01;

  typedef logic [3:0] tile_coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RANGE,
    ST_READ,
    ST_CHECK,
    ST_RESP
  } collide_state_t;

  function automatic tile_coord_t clamp_tile(input logic signed [15:0] t, input int limit);
    tile_coord_t r;
    if (t < 16'sd0) begin
      r = '0;
    end else if (int'(t) > limit - 1) begin
      r = 4'(limit - 1);
    end else begin
      r = t[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_collide_query_range.sv
// One axis of the box-to-tile conversion: signed pixel span to clamped tile range.
// Combinational; the top instantiates it once for x and once for y.
module tile_range
  import tile_collide_query_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic [15:0] pos,
  input  logic [3:0]  size,
  output tile_coord_t t0,
  output tile_coord_t t1
);

  logic signed [15:0] pos_s;
  logic signed [15:0] last_s;
  logic signed [15:0] t0_raw;
  logic signed [15:0] t1_raw;

  assign pos_s  = signed'(pos);
  // Last covered pixel; only meaningful for size >= 1, which the FSM guarantees.
  assign last_s = pos_s + signed'({12'd0, size}) - 16'sd1;
  assign t0_raw = pos_s >>> TILE_SHIFT;
  assign t1_raw = last_s >>> TILE_SHIFT;

  assign t0 = clamp_tile(t0_raw, LIMIT);
  assign t1 = clamp_tile(t1_raw, LIMIT);

endmodule

// File: rtl/tile_collide_query.sv
// Walks the 8x8 tiles covered by a pixel box through a synchronous flag RAM and
// reports whether any is solid, with the first hit tile in row-major order.
module tile_collide_query
  import tile_collide_query_pkg::*;
#(
  parameter int         MAP_W      = MAP_W_DEF,
  parameter int         MAP_H      = MAP_H_DEF,
  parameter logic [7:0] SOLID_MASK = SOLID_MASK_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [15:0] req_x_i,
  input  logic [15:0] req_y_i,
  input  logic [3:0]  req_w_i,
  input  logic [3:0]  req_h_i,
  output logic        map_rd_o,
  output logic [7:0]  map_addr_o,
  input  logic [7:0]  map_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        resp_solid_o,
  output logic [3:0]  resp_tx_o,
  output logic [3:0]  resp_ty_o
);

  collide_state_t state;
  logic [15:0]    x_reg;
  logic [15:0]    y_reg;
  logic [3:0]     w_reg;
  logic [3:0]     h_reg;
  tile_coord_t    cx;
  tile_coord_t    cy;
  tile_coord_t    tx0;
  tile_coord_t    tx1;
  tile_coord_t    ty0;
  tile_coord_t    ty1;
  tile_coord_t    cx_next;
  tile_coord_t    cy_next;
  logic           hit;
  logic           last_tile;

  // Tile bounds stay valid for the whole query since the box registers are frozen.
  tile_range #(.LIMIT(MAP_W)) u_range_x (
    .pos (x_reg),
    .size(w_reg),
    .t0  (tx0),
    .t1  (tx1)
  );

  tile_range #(.LIMIT(MAP_H)) u_range_y (
    .pos (y_reg),
    .size(h_reg),
    .t0  (ty0),
    .t1  (ty1)
  );

  function automatic logic [7:0] tile_addr(input tile_coord_t tx, input tile_coord_t ty);
    return 8'(int'(ty) * MAP_W + int'(tx));
  endfunction

  assign hit       = (map_data_i & SOLID_MASK) != 8'h00;
  assign last_tile = (cx == tx1) && (cy == ty1);
  assign cx_next   = (cx == tx1) ? tx0 : cx + 4'd1;
  assign cy_next   = (cx == tx1) ? cy + 4'd1 : cy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      cx           <= '0;
      cy           <= '0;
      req_ready_o  <= 1'b1;
      map_rd_o     <= 1'b0;
      map_addr_o   <= '0;
      resp_valid_o <= 1'b0;
      resp_solid_o <= 1'b0;
      resp_tx_o    <= '0;
      resp_ty_o    <= '0;
    end else begin
      map_rd_o   <= 1'b0;
      map_addr_o <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            x_reg       <= req_x_i;
            y_reg       <= req_y_i;
            w_reg       <= req_w_i;
            h_reg       <= req_h_i;
            req_ready_o <= 1'b0;
            state       <= ST_RANGE;
          end
        end
        ST_RANGE: begin
          if (w_reg == 4'd0 || h_reg == 4'd0) begin
            resp_solid_o <= 1'b0;
            resp_tx_o    <= '0;
            resp_ty_o    <= '0;
            resp_valid_o <= 1'b1;
            state        <= ST_RESP;
          end else begin
            cx         <= tx0;
            cy         <= ty0;
            map_rd_o   <= 1'b1;
            map_addr_o <= tile_addr(tx0, ty0);
            state      <= ST_READ;
          end
        end
        ST_READ: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (hit) begin
            resp_solid_o <= 1'b1;
            resp_tx_o    <= cx;
            resp_ty_o    <= cy;
            resp_valid_o <= 1'b1;
            state        <= ST_RESP;
          end else if (last_tile) begin
            resp_solid_o <= 1'b0;
            resp_tx_o    <= '0;
            resp_ty_o    <= '0;
            resp_valid_o <= 1'b1;
            state        <= ST_RESP;
          end else begin
            cx         <= cx_next;
            cy         <= cy_next;
            map_rd_o   <= 1'b1;
            map_addr_o <= tile_addr(cx_next, cy_next);
            state      <= ST_READ;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tile_collide_query.md
# tile_collide_query

Sequential collision responder that answers "is any solid tile under this box?" queries from the player/object movement logic. It takes a pixel-space box (x, y, w, h) and walks the covered 8x8 tiles of the current 16x16-tile room through a synchronous map-flag memory. It returns solid/clear plus the first hit tile coordinate, which callers use for snapping. It sits between the movement stage (initiator) and the room flag RAM.

## Interface
- MAP_W, 16, room width in tiles
- MAP_H, 16, room height in tiles
- SOLID_MASK, 8'h01, flag bits that make a tile solid
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  query valid
- req_ready_o  output  1  query accepted when valid&&ready
- req_x_i  input  16  box left, signed pixels
- req_y_i  input  16  box top, signed pixels
- req_w_i  input  4  box width, pixels (0..15)
- req_h_i  input  4  box height, pixels (0..15)
- map_rd_o  output  1  map read strobe
- map_addr_o  output  8  tile address = ty*MAP_W + tx
- map_data_i  input  8  tile flags, valid 1 cycle after map_rd_o
- resp_valid_o  output  1  result valid
- resp_ready_i  input  1  result consumed when valid&&ready
- resp_solid_o  output  1  1 = at least one solid tile
- resp_tx_o  output  4  first solid tile x (0 if clear)
- resp_ty_o  output  4  first solid tile y (0 if clear)

## Operation
- States: IDLE, RANGE, READ, CHECK, RESP.
- IDLE: req_ready_o=1. On handshake, register x, y, w, h and go to RANGE.
- RANGE: if w==0 or h==0, load a clear result and go to RESP. Otherwise compute tx0=x>>>3, tx1=(x+w-1)>>>3, ty0=y>>>3, ty1=(y+h-1)>>>3.
  - Arithmetic is signed 16-bit; the shift is arithmetic.
  - Each tile index is clamped to [0, MAP_W-1] / [0, MAP_H-1].
  - Load cursor (cx,cy)=(tx0,ty0) and go to READ.
- READ: drive map_rd_o=1 and map_addr_o={cy,cx}; go to CHECK.
- CHECK: evaluate (map_data_i & SOLID_MASK)!=0.
  - Hit: latch solid=1, tx=cx, ty=cy; go to RESP (early out).
  - Miss with cx==tx1 and cy==ty1: latch a clear result; go to RESP.
  - Otherwise advance the cursor row-major (cx++; at tx1 wrap to tx0 and cy++); go to READ.
- RESP: resp_valid_o=1 and resp_* are held stable until resp_ready_i, then go to IDLE. req_ready_o=0 in every state except IDLE.
- Clamping means boxes fully outside the room test the edge row/column; this matches game behaviour.
- map_addr_o is 0 and map_rd_o is 0 outside READ.

## Timing
- Reset values: state IDLE, req_ready_o=1, map_rd_o=0, map_addr_o=0, resp_valid_o=0, resp_solid_o=0, resp_tx_o=0, resp_ty_o=0.
- Handshake cycle = cycle 0.
- Empty box: resp_valid_o at cycle 2.
- First tile solid, or single-tile box: resp_valid_o at cycle 4.
- Each additional tile read adds 2 cycles. Worst case is a 3x3 box: cycle 20.
- The earliest back-to-back request is accepted in the cycle after the response handshake.
- Asynchronous reset at any state aborts the query immediately. Outputs take their reset values and no response is produced for the aborted query.

## Structure
- utils package holds:
  - tile_coord_t (4-bit)
  - TILE_SHIFT=3
  - MAP_W/MAP_H defaults
  - SOLID flag mask constant
  - the collide state enum
- One combinational sub-module, tile_range, performs signed shift and clamp for one axis (pos, size -> t0, t1). It is instantiated twice.
- Everything else is a single FSM plus the cursor and result registers.

## Test plan
- All map flags 0; x=10, y=20, w=6, h=5 -> map reads at addresses 33 then 49; resp_solid=0 at cycle 6.
- Flag 0x01 at tile (1,3); same query -> resp_solid=1, tx=1, ty=3, valid at cycle 6.
- Tile (0,0) solid; x=6, y=6, w=6, h=6 -> exactly one read (address 0); resp_solid=1, tx=0, ty=0 at cycle 4.
- x=16'hFFFC, y=130, w=6, h=5 (clamp) -> single read at address 240. Result follows that tile's flags.
- Flag 0x02 only with SOLID_MASK=0x01; also w=0 -> not solid, and the w=0 query responds at cycle 2 with no reads.
- Hold resp_ready_i low for 5 cycles -> resp_* stable and req_ready_o=0 throughout. Then assert rst_ni low during READ -> resp_valid_o=0 and req_ready_o=1 after release.
